instr_encoder: RTL and testbench
================================

Name: instr_encoder

Overview:
- Write side of the 8-bit instruction format: takes instruction fields (opcode, rdest, rsrc, imm) one beat at a time over a valid/ready handshake.
- Packs each beat into the 8-bit instruction word the core's decoder expects.
- Writes the words into consecutive program-memory locations starting at a given base address.
- Used by the boot/program loader and by test benches to fill instruction memory; checks field consistency and memory overflow.

Parameters:
- ADDR_W, 4, program memory address width; depth = 2^ADDR_W words.
- IMM_OPCODE, 4'b0101, opcode that selects MOV-immediate packing.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  begin a load session (sampled in IDLE only).
- base_addr  in  ADDR_W  first write address, latched on start.
- in_valid  in  1  field beat valid.
- in_ready  out  1  encoder accepts beat.
- in_opcode  in  4  opcode field.
- in_rdest  in  2  destination register.
- in_rsrc  in  2  source register (ignored for IMM_OPCODE).
- in_imm  in  4  immediate (used only for IMM_OPCODE).
- in_last  in  1  final beat of session.
- mem_we  out  1  program memory write enable.
- mem_addr  out  ADDR_W  write address.
- mem_wdata  out  8  packed instruction.
- busy  out  1  session active (LOAD or FINISH).
- done  out  1  one-cycle end-of-session pulse.
- err  out  1  error flag; sticky until next start.
- err_code  out  2  00 none, 01 field conflict, 10 overflow.
- count  out  ADDR_W+1  words written this session.

Behaviour:
- Reset (async, immediate): state IDLE; all outputs 0 (in_ready, mem_we, mem_addr, mem_wdata, busy, done, err, err_code, count).
- States:
  - IDLE: in_ready=0; in_valid ignored. On start: addr_ptr<=base_addr, count<=0, err/err_code<=0, go to LOAD.
  - LOAD: in_ready=1 every cycle; start ignored. A beat is accepted when in_valid && in_ready.
  - FINISH: lasts exactly one cycle; in_ready=0; done=1; next state IDLE.
- Packing:
  - Opcode != IMM_OPCODE: word = {in_opcode, in_rdest, in_rsrc}.
  - Opcode == IMM_OPCODE: word = {IMM_OPCODE, in_imm}; in_rsrc ignored.
- Field conflict: on an IMM_OPCODE beat with in_rdest != in_imm[3:2] (rdest and imm share bits [3:2]):
  - beat dropped, no write;
  - err<=1, err_code<=01;
  - go to FINISH regardless of in_last.
- Write timing: beat accepted in cycle N -> mem_we=1 in cycle N+1, with registered mem_addr=addr_ptr and mem_wdata=word.
  - addr_ptr increments modulo 2^ADDR_W (wraps past the top); count increments.
  - mem_we is low in any cycle without a write.
- Throughput: one beat per cycle; back-to-back beats give consecutive mem_we cycles.
- Last beat: accepted with in_last=1 in cycle N -> next state FINISH; its write occurs in cycle N+1 together with done=1.
- Overflow: a beat accepted while count == 2^ADDR_W is dropped (no write); err<=1, err_code<=10, go to FINISH.
- Error precedence: if both conditions could apply to the same beat, overflow wins.
- done: asserted only in FINISH; never two consecutive cycles.
- busy: =1 in LOAD and FINISH.
- Register hold: count, err and err_code hold after FINISH until the next start. mem_addr and mem_wdata hold their last values; only mem_we qualifies them.
- Reset mid-session: abandons the session immediately; no partial write is completed.

Test Plan:
1. start, base_addr=0; beats {op 0001, rd 2, rs 3}, then {op 0101, rd 1, imm 6, last} -> mem_we at addr 0 data 8'h1B, then addr 1 data 8'h56 with done=1; count=2, err=0.
2. start; beat {op 0101, rd 3, imm 2, last=0} -> no mem_we; next cycle done=1, err=1, err_code=01, count=0; return to IDLE.
3. ADDR_W=2, base_addr=2; 5 beats, none last -> writes at addrs 2,3,0,1; 5th beat dropped; done=1, err_code=10, count=4.
4. in_valid held high for 3 beats (third last) -> mem_we high 3 consecutive cycles, addresses base, base+1, base+2; done coincides with third write.
5. rst pulsed mid-LOAD between clock edges -> mem_we, in_ready and busy drop to 0 without waiting for an edge; a following start runs a clean session from new base_addr.
6. in_valid pulses in IDLE -> in_ready=0, no writes. start pulsed during LOAD -> addr_ptr and count unaffected.

Source files
------------

// File: rtl/instr_encoder.sv
`default_nettype none
// ============================================================================
// Module  : instr_encoder
// Brief   : Packs instruction field beats into 8-bit words and writes them to
//           consecutive program-memory locations, flagging conflicts/overflow.
// Revision: 1.0
// ============================================================================
module instr_encoder #(
    parameter int         ADDR_W     = 4,
    parameter logic [3:0] IMM_OPCODE = 4'b0101
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_opcode,
    input  logic [1:0]        in_rdest,
    input  logic [1:0]        in_rsrc,
    input  logic [3:0]        in_imm,
    input  logic              in_last,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code,
    output logic [ADDR_W:0]   count
);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_LOAD   = 2'd1;
    localparam logic [1:0] c_FINISH = 2'd2;

    localparam logic [1:0] c_ERR_NONE     = 2'b00;
    localparam logic [1:0] c_ERR_CONFLICT = 2'b01;
    localparam logic [1:0] c_ERR_OVERFLOW = 2'b10;

    localparam logic [ADDR_W:0] c_DEPTH = {1'b1, {ADDR_W{1'b0}}};

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_ptr_q;
    logic [ADDR_W:0]   count_q;
    logic              err_q;
    logic [1:0]        err_code_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [7:0]        mem_wdata_q;

    logic              w_session_start;
    logic              w_accept;
    logic              w_overflow;
    logic              w_conflict;
    logic              w_is_imm;
    logic [7:0]        w_word;

    assign w_session_start = (state_q == c_IDLE) && start;
    assign w_accept        = (state_q == c_LOAD) && in_valid;
    assign w_is_imm        = (in_opcode == IMM_OPCODE);
    assign w_overflow      = (count_q == c_DEPTH);
    // rdest doubles as imm[3:2] in the immediate format, so they must agree
    assign w_conflict      = w_is_imm && (in_rdest != in_imm[3:2]);
    assign w_word          = w_is_imm ? {IMM_OPCODE, in_imm}
                                      : {in_opcode, in_rdest, in_rsrc};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= c_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            c_IDLE: begin
                if (start) begin
                    state_d = c_LOAD;
                end
            end
            c_LOAD: begin
                if (in_valid && (w_overflow || w_conflict || in_last)) begin
                    state_d = c_FINISH;
                end
            end
            c_FINISH: begin
                state_d = c_IDLE;
            end
            default: begin
                state_d = c_IDLE;
            end
        endcase
    end

    always_comb begin
        in_ready = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state_q)
            c_LOAD: begin
                in_ready = 1'b1;
                busy     = 1'b1;
            end
            c_FINISH: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: begin
                in_ready = 1'b0;
            end
        endcase
    end

    // Overflow is tested before conflict so it takes precedence on one beat
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_ptr_q  <= '0;
            count_q     <= '0;
            err_q       <= 1'b0;
            err_code_q  <= c_ERR_NONE;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            mem_we_q <= 1'b0;
            if (w_session_start) begin
                addr_ptr_q <= base_addr;
                count_q    <= '0;
                err_q      <= 1'b0;
                err_code_q <= c_ERR_NONE;
            end else if (w_accept) begin
                if (w_overflow) begin
                    err_q      <= 1'b1;
                    err_code_q <= c_ERR_OVERFLOW;
                end else if (w_conflict) begin
                    err_q      <= 1'b1;
                    err_code_q <= c_ERR_CONFLICT;
                end else begin
                    mem_we_q    <= 1'b1;
                    mem_addr_q  <= addr_ptr_q;
                    mem_wdata_q <= w_word;
                    addr_ptr_q  <= addr_ptr_q + ADDR_W'(1);
                    count_q     <= count_q + (ADDR_W + 1)'(1);
                end
            end
        end
    end

    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign err       = err_q;
    assign err_code  = err_code_q;
    assign count     = count_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_encoder.sv
`default_nettype none
// ============================================================================
// Module  : tb_instr_encoder
// Brief   : Self-checking bench for instr_encoder against a session-level model.
// Revision: 1.0
// ============================================================================
module tb_instr_encoder;

    localparam int         AW    = 2;
    localparam int         DEPTH = 1 << AW;
    localparam logic [3:0] IMM   = 4'b0101;

    typedef struct {
        logic [3:0] op;
        logic [1:0] rd;
        logic [1:0] rs;
        logic [3:0] imm;
        logic       last;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [3:0]    in_opcode = '0;
    logic [1:0]    in_rdest = '0;
    logic [1:0]    in_rsrc = '0;
    logic [3:0]    in_imm = '0;
    logic          in_last = 1'b0;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_wdata;
    logic          busy;
    logic          done;
    logic          err;
    logic [1:0]    err_code;
    logic [AW:0]   count;

    int    checks = 0;
    int    errors = 0;
    beat_t bq[$];

    instr_encoder #(.ADDR_W(AW), .IMM_OPCODE(IMM)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_opcode (in_opcode),
        .in_rdest  (in_rdest),
        .in_rsrc   (in_rsrc),
        .in_imm    (in_imm),
        .in_last   (in_last),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .err_code  (err_code),
        .count     (count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Instruction word from the format rules, in plain arithmetic
    function automatic int model_word(input beat_t b);
        if (b.op == IMM) return int'(b.op) * 16 + int'(b.imm);
        return int'(b.op) * 16 + int'(b.rd) * 4 + int'(b.rs);
    endfunction

    function automatic beat_t mk(input int op, input int rd, input int rs, input int imm, input bit last);
        beat_t b;
        b.op   = 4'(op);
        b.rd   = 2'(rd);
        b.rs   = 2'(rs);
        b.imm  = 4'(imm);
        b.last = last;
        return b;
    endfunction

    function automatic beat_t rand_beat();
        beat_t b;
        b.op   = ($urandom_range(0, 2) == 0) ? IMM : 4'($urandom_range(0, 15));
        b.rd   = 2'($urandom);
        b.rs   = 2'($urandom);
        b.imm  = 4'($urandom);
        b.last = 1'b0;
        if (b.op == IMM && $urandom_range(0, 4) != 0) b.imm[3:2] = b.rd;
        return b;
    endfunction

    // Plays the queued beats as one session and checks every cycle against the model
    task automatic run_session(input int base, input bit gaps, input bit poke);
        int    cnt;
        int    code;
        bit    ended;
        bit    exp_we;
        int    i;
        beat_t b;
        cnt   = 0;
        code  = 0;
        ended = 0;
        i     = 0;
        start     = 1'b1;
        base_addr = base[AW-1:0];
        tick();
        start = 1'b0;
        check("sess_busy", busy, 1);
        check("sess_ready", in_ready, 1);
        check("sess_count0", count, 0);
        check("sess_err0", err, 0);
        while (!ended && i < bq.size()) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                in_valid = 1'b0;
                tick();
                check("gap_we", mem_we, 0);
                check("gap_done", done, 0);
            end
            b         = bq[i];
            in_opcode = b.op;
            in_rdest  = b.rd;
            in_rsrc   = b.rs;
            in_imm    = b.imm;
            in_last   = b.last;
            in_valid  = 1'b1;
            start     = poke ? 1'($urandom_range(0, 1)) : 1'b0;
            tick();
            in_valid = 1'b0;
            start    = 1'b0;
            exp_we   = 0;
            if (cnt == DEPTH) begin
                ended = 1;
                code  = 2;
            end else if (b.op == IMM && int'(b.rd) != int'(b.imm) / 4) begin
                ended = 1;
                code  = 1;
            end else begin
                exp_we = 1;
                check("wr_addr", mem_addr, (base + cnt) % DEPTH);
                check("wr_data", mem_wdata, model_word(b));
                cnt++;
                if (b.last) ended = 1;
            end
            check("wr_we", mem_we, exp_we);
            check("done", done, ended);
            check("count", count, cnt);
            check("err", err, code != 0);
            check("err_code", err_code, code);
            i++;
        end
        check("session_ended", ended, 1);
        tick();
        check("post_busy", busy, 0);
        check("post_done", done, 0);
        check("post_we", mem_we, 0);
        check("post_count", count, cnt);
        check("post_err_code", err_code, code);
    endtask

    initial begin
        // Reset state
        #3;
        check("rst_ready", in_ready, 0);
        check("rst_we", mem_we, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_wdata", mem_wdata, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_err_code", err_code, 0);
        check("rst_count", count, 0);
        tick();
        rst = 1'b0;
        tick();

        // Directed packing example: 0x1B then 0x56 with done
        bq = {};
        bq.push_back(mk(1, 2, 3, 0, 0));
        bq.push_back(mk(5, 1, 0, 6, 1));
        run_session(0, 0, 0);

        // Field conflict on first beat
        bq = {};
        bq.push_back(mk(5, 3, 0, 2, 0));
        run_session(1, 0, 0);

        // Overflow with wrap: writes 2,3,0,1, fifth dropped
        bq = {};
        for (int k = 0; k < 5; k++) bq.push_back(mk(k + 1, k % 4, 3 - (k % 4), 0, 0));
        run_session(2, 0, 0);

        // Three back-to-back beats, third last
        bq = {};
        bq.push_back(mk(2, 1, 1, 0, 0));
        bq.push_back(mk(5, 2, 0, 9, 0));
        bq.push_back(mk(15, 3, 2, 0, 1));
        run_session(3, 0, 0);

        // in_valid in IDLE is ignored
        for (int k = 0; k < 3; k++) begin
            in_valid  = 1'b1;
            in_opcode = 4'($urandom);
            tick();
            check("idle_ready", in_ready, 0);
            check("idle_we", mem_we, 0);
            check("idle_busy", busy, 0);
        end
        in_valid = 1'b0;

        // Asynchronous reset mid-session
        start     = 1'b1;
        base_addr = 2'd1;
        tick();
        start     = 1'b0;
        in_opcode = 4'd3;
        in_rdest  = 2'd0;
        in_rsrc   = 2'd1;
        in_last   = 1'b0;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        check("mid_we", mem_we, 1);
        #2 rst = 1'b1;
        #1;
        check("arst_we", mem_we, 0);
        check("arst_ready", in_ready, 0);
        check("arst_busy", busy, 0);
        check("arst_count", count, 0);
        tick();
        rst = 1'b0;
        tick();
        bq = {};
        bq.push_back(mk(7, 1, 2, 0, 0));
        bq.push_back(mk(5, 0, 0, 3, 1));
        run_session(3, 0, 0);

        // Randomized sessions with idle gaps and start pokes during LOAD
        for (int s = 0; s < 12; s++) begin
            int len;
            bq  = {};
            len = $urandom_range(1, 6);
            for (int k = 0; k < len; k++) bq.push_back(rand_beat());
            bq[len - 1].last = 1'b1;
            run_session($urandom_range(0, DEPTH - 1), 1, s[0]);
            repeat ($urandom_range(0, 2)) tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
